// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive buffer controller.
package uart_pkg;

    localparam int unsigned RX_ENTRY_W = 10;

    localparam logic [1:0] TRIG_ONE       = 2'b00;
    localparam logic [1:0] TRIG_QUARTER   = 2'b01;
    localparam logic [1:0] TRIG_HALF      = 2'b10;
    localparam logic [1:0] TRIG_NEAR_FULL = 2'b11;

    typedef enum logic [1:0] {
        TO_IDLE  = 2'b00,
        TO_ARMED = 2'b01,
        TO_FIRED = 2'b10
    } to_state_e;

    typedef struct packed {
        logic       frm_err;
        logic       par_err;
        logic [7:0] data;
    } rx_entry_t;

    function automatic int unsigned trig_level(input logic [1:0] lvl,
                                               input int unsigned depth);
        int unsigned thr;
        case (lvl)
            TRIG_ONE:       thr = 1;
            TRIG_QUARTER:   thr = depth / 4;
            TRIG_HALF:      thr = depth / 2;
            TRIG_NEAR_FULL: thr = depth - 2;
            default:        thr = 1;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/uart_rx_buf_ctrl_if.sv
// Receiver-side strobes and register-side controls/status of the RX buffer controller.
interface uart_rx_buf_ctrl_if #(
    parameter int unsigned AW = 4
) ();

    logic          baud_tick;
    logic          rx_done;
    logic [7:0]    rx_data;
    logic          par_err;
    logic          frm_err;
    logic          fifo_en;
    logic          fifo_rst;
    logic [1:0]    trig_lvl;
    logic          rd_en;
    logic          ovr_clr;
    logic [7:0]    rd_data;
    logic          rd_perr;
    logic          rd_ferr;
    logic [AW:0]   rx_count;
    logic          rx_empty;
    logic          rx_full;
    logic          overrun;
    logic          rx_trig;
    logic          rx_timeout;
    logic          rx_int;

    modport slave (
        input  baud_tick, rx_done, rx_data, par_err, frm_err,
        input  fifo_en, fifo_rst, trig_lvl, rd_en, ovr_clr,
        output rd_data, rd_perr, rd_ferr, rx_count, rx_empty, rx_full,
        output overrun, rx_trig, rx_timeout, rx_int
    );

    modport master (
        output baud_tick, rx_done, rx_data, par_err, frm_err,
        output fifo_en, fifo_rst, trig_lvl, rd_en, ovr_clr,
        input  rd_data, rd_perr, rd_ferr, rx_count, rx_empty, rx_full,
        input  overrun, rx_trig, rx_timeout, rx_int
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Register-array FIFO for received entries with a runtime capacity limit (1 or DEPTH).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [RX_ENTRY_W-1:0] wdata,
    input  logic                  pop,
    input  logic                  clr,
    input  logic [AW:0]           cap,
    output logic [RX_ENTRY_W-1:0] rdata,
    output logic [AW:0]           count,
    output logic                  empty,
    output logic                  full,
    output logic                  push_ok,
    output logic                  pop_ok
);

    logic [RX_ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;

    assign empty   = (count_q == '0);
    assign full    = (count_q >= cap);
    assign pop_ok  = pop & ~clr & ~empty;
    // A same-cycle pop frees the slot first, so a push into a full FIFO still lands.
    assign push_ok = push & ~clr & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_rx_buf_ctrl.sv
// UART receive buffer controller: FIFO/holding-register queueing, sticky overrun,
// trigger-level compare and character-timeout interrupt.
module uart_rx_buf_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned TO_TICKS = 640,
    parameter int unsigned TO_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_rx_buf_ctrl_if.slave bus
);

    logic        fifo_en_q;
    logic        clr;
    logic [AW:0] cap;
    logic [AW:0] count;
    logic [AW:0] trig_thr;
    logic        empty, full, push_ok, pop_ok;
    logic        last_pop;
    rx_entry_t   wentry, rentry;

    logic        overrun_q, overrun_d;
    to_state_e   to_state_q, to_state_d;
    logic [TO_W-1:0] timer_q, timer_d;

    // A mode switch flushes the buffer so a stale DEPTH-deep queue never leaks into 16450 mode.
    assign clr = bus.fifo_rst | (bus.fifo_en ^ fifo_en_q);
    assign cap = bus.fifo_en ? (AW+1)'(DEPTH) : (AW+1)'(1);

    assign wentry = '{frm_err: bus.frm_err, par_err: bus.par_err, data: bus.rx_data};

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (bus.rx_done),
        .wdata   (wentry),
        .pop     (bus.rd_en),
        .clr     (clr),
        .cap     (cap),
        .rdata   (rentry),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .push_ok (push_ok),
        .pop_ok  (pop_ok)
    );

    // Overrun: set has priority over the LSR-read clear.
    always_comb begin
        overrun_d = overrun_q;
        if (bus.rx_done && !clr && !push_ok) begin
            overrun_d = 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    assign last_pop = pop_ok & ~push_ok & (count == (AW+1)'(1));

    always_comb begin
        to_state_d = to_state_q;
        timer_d    = timer_q;
        if (clr || !bus.fifo_en) begin
            to_state_d = TO_IDLE;
            timer_d    = '0;
        end else begin
            unique case (to_state_q)
                TO_IDLE: begin
                    if (push_ok) begin
                        to_state_d = TO_ARMED;
                        timer_d    = '0;
                    end
                end
                TO_ARMED: begin
                    if (last_pop) begin
                        to_state_d = TO_IDLE;
                        timer_d    = '0;
                    end else if (push_ok || pop_ok) begin
                        timer_d = '0;
                    end else if (bus.baud_tick) begin
                        if (timer_q == TO_W'(TO_TICKS - 1)) begin
                            to_state_d = TO_FIRED;
                            timer_d    = '0;
                        end else begin
                            timer_d = timer_q + TO_W'(1);
                        end
                    end
                end
                TO_FIRED: begin
                    if (last_pop) begin
                        to_state_d = TO_IDLE;
                        timer_d    = '0;
                    end else if (push_ok || pop_ok) begin
                        to_state_d = TO_ARMED;
                        timer_d    = '0;
                    end
                end
                default: begin
                    to_state_d = TO_IDLE;
                    timer_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_en_q  <= 1'b0;
            overrun_q  <= 1'b0;
            to_state_q <= TO_IDLE;
            timer_q    <= '0;
        end else begin
            fifo_en_q  <= bus.fifo_en;
            overrun_q  <= overrun_d;
            to_state_q <= to_state_d;
            timer_q    <= timer_d;
        end
    end

    assign trig_thr = (AW+1)'(trig_level(bus.trig_lvl, DEPTH));

    assign bus.rd_data    = rentry.data;
    assign bus.rd_perr    = rentry.par_err;
    assign bus.rd_ferr    = rentry.frm_err;
    assign bus.rx_count   = count;
    assign bus.rx_empty   = empty;
    assign bus.rx_full    = full;
    assign bus.overrun    = overrun_q;
    assign bus.rx_trig    = bus.fifo_en ? (count >= trig_thr) : ~empty;
    assign bus.rx_timeout = (to_state_q == TO_FIRED);
    assign bus.rx_int     = bus.rx_trig | bus.rx_timeout;

endmodule
